// File: rtl/clint_mc_if.sv
// clint_mc_if: valid/ready peripheral bus between a CPU and the clint_mc
// core-local interruptor. One request per valid cycle; ready answers exactly
// one cycle later with rdata for reads.
interface clint_mc_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;
  logic              ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/clint_mc.sv
// clint_mc: multi-hart core-local interruptor.
// One 64-bit mtime counter advanced by a programmable prescaler off clk,
// one 64-bit mtimecmp and one msip bit per hart, per-hart mtip/msip lines.
// Optional feature macro CLINT_MTIME_SNAPSHOT_EN: a read of the mtime low
// word latches the high word into a shadow returned by high-word reads.
module clint_mc #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_CORES = 1,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  clint_mc_if.slave          bus,
  output logic [N_CORES-1:0] mtip,
  output logic [N_CORES-1:0] msip
);

  localparam logic [31:0] A_MSIP  = 32'h0000_0000;
  localparam logic [31:0] A_CMP   = 32'h0000_4000;
  localparam logic [31:0] A_CTRL  = 32'h0000_BFF0;
  localparam logic [31:0] A_PRESC = 32'h0000_BFF4;
  localparam logic [31:0] A_MTL   = 32'h0000_BFF8;
  localparam logic [31:0] A_MTH   = 32'h0000_BFFC;

  // byte-enable merge of a bus write into an existing word
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [DATA_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // decode
  logic [31:0]        word_addr;
  logic [N_CORES-1:0] sel_msip;
  logic [N_CORES-1:0] sel_cmp_lo;
  logic [N_CORES-1:0] sel_cmp_hi;
  logic               sel_ctrl, sel_presc, sel_mtl, sel_mth;
  logic               is_wr, is_rd;
  logic [DATA_W-1:0]  bmask;

  // state
  logic [63:0]        mtime_q, mtime_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               en_q, en_d;
  logic [63:0]        cmp_q [N_CORES];
  logic [63:0]        cmp_d [N_CORES];
  logic [N_CORES-1:0] msip_q, msip_d;
  logic [N_CORES-1:0] mtip_q, mtip_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               tick;
`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0]        shadow_q, shadow_d;
`endif

  // address decode and request classification
  always_comb begin
    word_addr  = 32'(bus.address) & 32'hFFFF_FFFC;
    sel_msip   = '0;
    sel_cmp_lo = '0;
    sel_cmp_hi = '0;
    for (int unsigned h = 0; h < N_CORES; h++) begin
      if (word_addr == A_MSIP + 4 * h)     sel_msip[h]   = 1'b1;
      if (word_addr == A_CMP + 8 * h)      sel_cmp_lo[h] = 1'b1;
      if (word_addr == A_CMP + 8 * h + 4)  sel_cmp_hi[h] = 1'b1;
    end
    sel_ctrl  = (word_addr == A_CTRL);
    sel_presc = (word_addr == A_PRESC);
    sel_mtl   = (word_addr == A_MTL);
    sel_mth   = (word_addr == A_MTH);
    is_wr     = bus.valid & (|bus.wstrb);
    is_rd     = bus.valid & ~(|bus.wstrb);
    bmask     = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                 {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  end

  // prescaler, mtime, control and per-hart register updates
  always_comb begin
    tick    = en_q & (pc_q == presc_q);
    pc_d    = pc_q;
    presc_d = presc_q;
    en_d    = en_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;

    if (en_q) pc_d = tick ? '0 : pc_q + PRESC_W'(1);

    if (is_wr) begin
      if (sel_ctrl && bus.wstrb[0]) en_d = bus.wdata[0];
      if (sel_presc) begin
        presc_d = PRESC_W'(merge(32'(presc_q), bus.wdata, bmask));
        pc_d    = '0;
      end
      // a bus write to either mtime word replaces the tick result entirely,
      // so the other word keeps its pre-tick value and no carry propagates
      if (sel_mtl) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], bus.wdata, bmask)};
      if (sel_mth) mtime_d = {merge(mtime_q[63:32], bus.wdata, bmask), mtime_q[31:0]};
      for (int unsigned h = 0; h < N_CORES; h++) begin
        if (sel_msip[h] && bus.wstrb[0]) msip_d[h] = bus.wdata[0];
        if (sel_cmp_lo[h]) cmp_d[h] = {cmp_q[h][63:32], merge(cmp_q[h][31:0], bus.wdata, bmask)};
        if (sel_cmp_hi[h]) cmp_d[h] = {merge(cmp_q[h][63:32], bus.wdata, bmask), cmp_q[h][31:0]};
      end
    end
  end

  // read mux sampled from current register state; response one cycle later
  always_comb begin
    ready_d = bus.valid;
    rdata_d = '0;
`ifdef CLINT_MTIME_SNAPSHOT_EN
    shadow_d = shadow_q;
    if (is_rd && sel_mtl) shadow_d = mtime_q[63:32];
`endif
    if (is_rd) begin
      if (sel_ctrl)  rdata_d = {31'b0, en_q};
      if (sel_presc) rdata_d = 32'(presc_q);
      if (sel_mtl)   rdata_d = mtime_q[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
      if (sel_mth)   rdata_d = shadow_q;
`else
      if (sel_mth)   rdata_d = mtime_q[63:32];
`endif
      for (int unsigned h = 0; h < N_CORES; h++) begin
        if (sel_msip[h])   rdata_d = {31'b0, msip_q[h]};
        if (sel_cmp_lo[h]) rdata_d = cmp_q[h][31:0];
        if (sel_cmp_hi[h]) rdata_d = cmp_q[h][63:32];
      end
    end
  end

  // timer interrupt compare, registered one cycle behind mtime/mtimecmp
  always_comb begin
    mtip_d = '0;
    for (int unsigned h = 0; h < N_CORES; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q <= '0;
      pc_q    <= '0;
      presc_q <= '0;
      en_q    <= 1'b1;
      msip_q  <= '0;
      mtip_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int unsigned h = 0; h < N_CORES; h++) begin
        cmp_q[h] <= '1;
      end
`ifdef CLINT_MTIME_SNAPSHOT_EN
      shadow_q <= '0;
`endif
    end else begin
      mtime_q <= mtime_d;
      pc_q    <= pc_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      cmp_q   <= cmp_d;
`ifdef CLINT_MTIME_SNAPSHOT_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;

endmodule

// File: tb/tb_clint_mc.sv
// tb_clint_mc: directed bench for clint_mc with two harts. Requests push
// expected responses to a scoreboard queue; a negedge monitor pops and
// compares whenever ready is seen. Interrupt lines are checked inline.
module tb_clint_mc;

  localparam int unsigned NC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] mtip;
  logic [NC-1:0] msip;

  clint_mc_if #(.ADDR_W(16)) bus ();

  clint_mc #(
    .ADDR_W (16),
    .DATA_W (32),
    .N_CORES(NC),
    .PRESC_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .mtip (mtip),
    .msip (msip)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] exp;
    bit          chk_rd;
    bit          chk_ms;
    logic [1:0]  exp_ms;
    string       name;
  } ent_t;

  ent_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int unsigned act,
                         input int unsigned lo, input int unsigned hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic req(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input bit crd, input bit cms,
                     input logic [1:0] ems, input string name);
    ent_t e;
    bus.valid   = 1'b1;
    bus.address = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    e.cyc = cyc; e.exp = exp; e.chk_rd = crd; e.chk_ms = cms; e.exp_ms = ems; e.name = name;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string name);
    req(a, 32'h0, 4'h0, exp, 1'b1, 1'b0, 2'b00, name);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
    req(a, d, s, 32'h0, 1'b0, 1'b0, 2'b00, name);
  endtask

  task automatic wrm(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] ems, input string name);
    req(a, d, s, 32'h0, 1'b0, 1'b1, ems, name);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // scoreboard monitor: ready must come exactly one cycle after its request
  ent_t me;
  always @(negedge clk) begin
    if (bus.ready) begin
      if (sbq.size() == 0) begin
        chk("spurious_ready", {31'b0, bus.ready}, 32'h0);
      end else begin
        me = sbq.pop_front();
        chk({me.name, "_latency"}, cyc, me.cyc + 1);
        if (me.chk_rd) chk(me.name, bus.rdata, me.exp);
        if (me.chk_ms) chk({me.name, "_msip"}, 32'(msip), 32'(me.exp_ms));
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].cyc + 1) begin
      me = sbq.pop_front();
      chk({me.name, "_noready"}, {31'b0, bus.ready}, 32'h1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit          m0;

    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;

    // reset values on outputs
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mtip", 32'(mtip), 32'h0);
    chk("rst_msip", 32'(msip), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    // 1. register reset values and unmapped addresses
    rd(16'h0000, 32'h0, "msip0_rst");
    rd(16'h0004, 32'h0, "msip1_rst");
    rd(16'h4000, 32'hFFFF_FFFF, "cmp0_lo_rst");
    rd(16'h4004, 32'hFFFF_FFFF, "cmp0_hi_rst");
    rd(16'h4008, 32'hFFFF_FFFF, "cmp1_lo_rst");
    rd(16'h400C, 32'hFFFF_FFFF, "cmp1_hi_rst");
    rd(16'hBFF0, 32'h1, "ctrl_rst");
    rd(16'hBFF4, 32'h0, "presc_rst");
    rd(16'h0008, 32'h0, "unmapped_msip2");
    rd(16'h2000, 32'h0, "unmapped_2000");
    rd(16'h4010, 32'h0, "unmapped_cmp2");
    wr(16'h0008, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
    rd(16'h0008, 32'h0, "unmapped_after_wr");
    chk("idle_mtip", 32'(mtip), 32'h0);
    chk("idle_msip", 32'(msip), 32'h0);

    // byte strobes and prescaler width
    wr(16'hBFF4, 32'h1234_5678, 4'b0001, "presc_b0");
    rd(16'hBFF4, 32'h0000_0078, "presc_b0_rd");
    wr(16'hBFF4, 32'h1234_5678, 4'b0010, "presc_b1");
    rd(16'hBFF4, 32'h0000_5678, "presc_b1_rd");
    wr(16'hBFF4, 32'hFFFF_FFFF, 4'hF, "presc_all");
    rd(16'hBFF4, 32'h0000_FFFF, "presc_width_rd");
    wr(16'hBFF4, 32'h0, 4'hF, "presc_zero");

    // 3. software interrupts
    wrm(16'h0000, 32'h1, 4'hF, 2'b01, "msip0_set");
    wrm(16'h0004, 32'hFFFF_FFFF, 4'hF, 2'b11, "msip1_set");
    rd(16'h0004, 32'h1, "msip1_rd");
    rd(16'h0000, 32'h1, "msip0_rd");
    wrm(16'h0000, 32'h0, 4'hF, 2'b10, "msip0_clr");
    wrm(16'h0004, 32'h0, 4'hF, 2'b00, "msip1_clr");
    wrm(16'h0000, 32'h1, 4'b0010, 2'b00, "msip0_wrong_byte");

    // 2. prescaled timer interrupt on hart 1
    wr(16'hBFF4, 32'h3, 4'hF, "presc3");
    wr(16'hBFFC, 32'h0, 4'hF, "mth0");
    wr(16'hBFF8, 32'h0, 4'hF, "mtl0");
    wr(16'h4008, 32'd20, 4'hF, "cmp1_lo20");
    wr(16'h400C, 32'h0, 4'hF, "cmp1_hi0");
    wr(16'hBFF8, 32'h0, 4'hF, "mtl0_start");
    n = 0; m0 = 1'b0;
    while (!mtip[1] && n < 200) begin
      if (mtip[0]) m0 = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk_rng("mtip1_rise_delay", n, 79, 81);
    chk("mtip0_quiet", {31'b0, m0}, 32'h0);
    chk("mtip_after_rise", 32'(mtip), 32'h2);
    wr(16'h4008, 32'hFFFF_FFFF, 4'hF, "cmp1_raise");
    chk("mtip_cmp_edge", 32'(mtip), 32'h2);
    idle(1);
    chk("mtip_cleared", 32'(mtip), 32'h0);
    wr(16'h400C, 32'hFFFF_FFFF, 4'hF, "cmp1_hi_restore");
    wr(16'hBFF4, 32'h0, 4'hF, "presc0");

    // 4. wrap with PRESC=0, mtip pulse against all-ones compare
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF, "wrap_hi");
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF, "wrap_lo");
    chk("wrap_mtip_a", 32'(mtip), 32'h0);
    rd(16'hBFF8, 32'hFFFF_FFFE, "wrap_rd_fe");
    chk("wrap_mtip_b", 32'(mtip), 32'h0);
    rd(16'hBFF8, 32'hFFFF_FFFF, "wrap_rd_ff");
    chk("wrap_mtip_max", 32'(mtip), 32'h3);
    rd(16'hBFF8, 32'h0, "wrap_rd_0");
    chk("wrap_mtip_deassert", 32'(mtip), 32'h0);
    rd(16'hBFFC, 32'h0, "wrap_rd_hi");

    // halt
    wr(16'hBFF0, 32'h0, 4'hF, "ctrl_halt");
    rd(16'hBFF0, 32'h0, "ctrl_rd0");
    wr(16'hBFF8, 32'd1234, 4'hF, "halt_mtl");
    wr(16'hBFFC, 32'h7, 4'hF, "halt_mth");
    idle(50);
    rd(16'hBFF8, 32'd1234, "halt_hold_lo");
    rd(16'hBFFC, 32'h7, "halt_hold_hi");
    wr(16'hBFF0, 32'h1, 4'hF, "ctrl_run");
    rd(16'hBFF8, 32'd1234, "run_first");
    rd(16'hBFF8, 32'd1235, "run_second");

    // 5. collision: write wins over tick, no carry into high word
    wr(16'hBFFC, 32'h5, 4'hF, "coll_hi");
    wr(16'hBFF8, 32'd100, 4'hF, "coll_lo");
    rd(16'hBFF8, 32'd100, "coll_rd100");
    rd(16'hBFF8, 32'd101, "coll_rd101");
    rd(16'hBFFC, 32'h5, "coll_rd_hi");

    // 6. snapshot / live high word
    wr(16'hBFFC, 32'h1, 4'hF, "snap_hi");
    wr(16'hBFF8, 32'hFFFF_FFF0, 4'hF, "snap_lo");
    rd(16'hBFF8, 32'hFFFF_FFF0, "snap_rd_lo");
    idle(40);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    rd(16'hBFFC, 32'h1, "snap_rd_hi");
`else
    rd(16'hBFFC, 32'h2, "snap_rd_hi");
`endif

    // reset mid-operation: ready high and a request pending
    wrm(16'h0000, 32'h1, 4'hF, 2'b01, "pre_rst_msip");
    wr(16'h4008, 32'h0, 4'hF, "pre_rst_cmp");
    bus.valid = 1'b1; bus.address = 16'hBFF0; bus.wstrb = 4'h0;
    @(posedge clk); #1;
    bus.address = 16'hBFF8;
    reset = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_ready", {31'b0, bus.ready}, 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    chk("midrst_msip", 32'(msip), 32'h0);
    chk("midrst_mtip", 32'(mtip), 32'h0);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
    rd(16'hBFF0, 32'h1, "post_rst_ctrl");
    rd(16'h4008, 32'hFFFF_FFFF, "post_rst_cmp1");
    rd(16'hBFF4, 32'h0, "post_rst_presc");
    rd(16'hBFFC, 32'h0, "post_rst_mth");
    idle(3);
    chk("sb_drained", sbq.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
